// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants for data_mem and its two-port arbiter: FSM state
// encodings, the word-zero constant and the address legality check.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [31:0] WORD_ZERO    = 32'h0000_0000;
  // Nonzero bits here mean misaligned or outside the 64 KiB byte array.
  localparam logic [31:0] ILLEGAL_MASK = 32'hFFFF_0003;

  function automatic logic addr_illegal(input logic [31:0] addr);
    return (addr & ILLEGAL_MASK) != WORD_ZERO;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way winner selection: round-robin on ties, or port 0
// always wins when FIXED_PRIO is nonzero.
module rr_pick2 #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_grant
);

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    o_valid = |i_req;
    o_grant = ~i_req[0];
    if (FIXED_PRIO == 0 && (&i_req)) begin
      o_grant = ~i_last;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of data_mem: IDLE -> ACCESS -> DONE per transaction,
// memory strobes decoded only from the state and registered request fields.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data,
  output logic        busy
);

  state_e      r_state;
  state_e      w_next;
  logic        r_port;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic        r_last;
  logic [31:0] r_p0_rdata;
  logic [31:0] r_p1_rdata;

  logic        w_any;
  logic        w_grant;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_illegal;

  rr_pick2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .i_req   ({p1_req, p0_req}),
    .i_last  (r_last),
    .o_valid (w_any),
    .o_grant (w_grant)
  );

  assign w_sel_we      = w_grant ? p1_we    : p0_we;
  assign w_sel_addr    = w_grant ? p1_addr  : p0_addr;
  assign w_sel_wdata   = w_grant ? p1_wdata : p0_wdata;
  assign w_sel_illegal = addr_illegal(w_sel_addr);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_port     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= WORD_ZERO;
      r_wdata    <= WORD_ZERO;
      r_err      <= 1'b0;
      r_last     <= 1'b1;
      r_p0_rdata <= WORD_ZERO;
      r_p1_rdata <= WORD_ZERO;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_any) begin
        r_port  <= w_grant;
        r_last  <= w_grant;
        r_we    <= w_sel_we;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_err   <= w_sel_illegal;
      end
      if (r_state == ST_ACCESS && !r_we) begin
        if (r_port) r_p1_rdata <= mem_read_data;
        else        r_p0_rdata <= mem_read_data;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = WORD_ZERO;
    mem_write_data = WORD_ZERO;
    p0_ack         = 1'b0;
    p1_ack         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_next = w_sel_illegal ? ST_DONE : ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_read       = ~r_we;
        mem_write      = r_we;
        mem_address    = r_addr;
        mem_write_data = r_wdata;
        w_next         = ST_DONE;
      end
      ST_DONE: begin
        p0_ack = ~r_port;
        p1_ack = r_port;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign p0_err   = p0_ack & r_err;
  assign p1_err   = p1_ack & r_err;
  assign p0_rdata = r_p0_rdata;
  assign p1_rdata = r_p1_rdata;
  assign busy     = (r_state != ST_IDLE);

endmodule
